// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that applies set/reset commands from NREQ requesters to a bank of NFLAG flags.
// Optional feature macro: SR_ARB_CONFLICT_CNT_EN adds a saturating count of {s,r}=11 commands.
module sr_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = $clog2(NFLAG),
    parameter int RQW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_s,
    input  logic [NREQ-1:0]      req_r,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      ack,
    output logic [NFLAG-1:0]     q,
    output logic                 busy,
    output logic [RQW-1:0]       grant_id
`ifdef SR_ARB_CONFLICT_CNT_EN
    ,
    output logic [7:0]           conflict_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StApply} state_e;

    state_e            r_state;
    logic [NREQ-1:0]   r_ack;
    logic [NFLAG-1:0]  r_q;
    logic              r_busy;
    logic [RQW-1:0]    r_grant;
    logic [RQW-1:0]    r_rr;
    logic              r_s;
    logic              r_r;
    logic [IDXW-1:0]   r_idx;

    logic              w_found;
    logic [RQW-1:0]    w_winner;
    logic              w_in_range;

    // First requesting id at or after the rr pointer, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[RQW'((int'(r_rr) + k) % NREQ)]) begin
                w_found  = 1'b1;
                w_winner = RQW'((int'(r_rr) + k) % NREQ);
            end
        end
    end

    assign w_in_range = int'(r_idx) < NFLAG;

`ifdef SR_ARB_CONFLICT_CNT_EN
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (r_state == StApply && r_s && r_r && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign conflict_cnt = r_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_ack   <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_grant <= '0;
            r_rr    <= '0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_ack <= '0;
                    if (w_found) begin
                        r_s     <= req_s[w_winner];
                        r_r     <= req_r[w_winner];
                        r_idx   <= req_idx[int'(w_winner)*IDXW +: IDXW];
                        r_grant <= w_winner;
                        r_busy  <= 1'b1;
                        r_state <= StApply;
                    end
                end
                StApply: begin
                    // Only 01 and 10 change the flag; 11 resolves to hold.
                    if ((r_s ^ r_r) && w_in_range) begin
                        r_q[r_idx] <= r_s;
                    end
                    r_ack   <= NREQ'(1) << r_grant;
                    r_rr    <= (int'(r_grant) == NREQ - 1) ? '0 : r_grant + 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ack      = r_ack;
    assign q        = r_q;
    assign busy     = r_busy;
    assign grant_id = r_grant;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Bench for sr_bank_arbiter: transaction-level model, directed cases, then random traffic.
module tb_sr_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IDXW  = 3;
    localparam int RQW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_s;
    logic [NREQ-1:0]      req_r;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      ack;
    logic [NFLAG-1:0]     q;
    logic                 busy;
    logic [RQW-1:0]       grant_id;
`ifdef SR_ARB_CONFLICT_CNT_EN
    logic [7:0]           conflict_cnt;
`endif

    always #5 clk = ~clk;

    sr_bank_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
        .clk(clk), .rst(rst), .req(req), .req_s(req_s), .req_r(req_r), .req_idx(req_idx),
        .ack(ack), .q(q), .busy(busy), .grant_id(grant_id)
`ifdef SR_ARB_CONFLICT_CNT_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: a flag array, an rr pointer and at most one command in flight.
    bit mq[NFLAG];
    int mrr, mgid, midx, mcc;
    bit mpend, ms, mr, mbusy;
    bit mack[NREQ];

    function automatic logic [NFLAG-1:0] mq_vec();
        logic [NFLAG-1:0] v;
        for (int i = 0; i < NFLAG; i++) v[i] = mq[i];
        return v;
    endfunction

    function automatic logic [NREQ-1:0] mack_vec();
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = mack[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NFLAG; i++) mq[i] = 1'b0;
        for (int i = 0; i < NREQ; i++) mack[i] = 1'b0;
        mrr = 0; mgid = 0; mpend = 0; mbusy = 0; mcc = 0;
    endtask

    task automatic model_step();
        int j;
        for (int i = 0; i < NREQ; i++) mack[i] = 1'b0;
        if (mpend) begin
            if (ms != mr && midx < NFLAG) mq[midx] = ms;
            if (ms && mr && mcc < 255) mcc++;
            mack[mgid] = 1'b1;
            mrr = (mgid + 1) % NREQ;
            mpend = 0;
            mbusy = 0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                j = (mrr + k) % NREQ;
                if (!mpend && req[j]) begin
                    mpend = 1;
                    mgid = j;
                    ms = req_s[j];
                    mr = req_r[j];
                    midx = int'(req_idx[j*IDXW +: IDXW]);
                    mbusy = 1;
                end
            end
        end
    endtask

    task automatic cmp_all();
        chk("q", 64'(q), 64'(mq_vec()));
        chk("ack", 64'(ack), 64'(mack_vec()));
        chk("busy", 64'(busy), 64'(mbusy));
        chk("grant_id", 64'(grant_id), 64'(mgid));
`ifdef SR_ARB_CONFLICT_CNT_EN
        chk("conflict_cnt", 64'(conflict_cnt), 64'(mcc));
`endif
    endtask

    // Active edge, model update, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic set_cmd(input int i, input bit s, input bit r, input int idx);
        req[i] = 1'b1;
        req_s[i] = s;
        req_r[i] = r;
        req_idx[i*IDXW +: IDXW] = IDXW'(idx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0; req_s = '0; req_r = '0; req_idx = '0;
        #1;
        model_reset();
        cmp_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int waitcnt[NREQ];

    initial begin
        rst = 1'b0;
        req = '0; req_s = '0; req_r = '0; req_idx = '0;
        model_reset();
        do_reset();
        chk("reset_q", 64'(q), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        tick();

        // 1: set flag 3 from requester 0
        set_cmd(0, 1, 0, 3);
        tick();
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_ack_early", 64'(ack), 64'h0);
        tick();
        chk("t1_ack", 64'(ack), 64'h1);
        chk("t1_q", 64'(q), 64'h08);
        chk("t1_gid", 64'(grant_id), 64'h0);
        req = '0;
        tick();

        // 2: reset flag 3
        set_cmd(0, 0, 1, 3);
        tick();
        chk("t2_busy", 64'(busy), 64'h1);
        tick();
        chk("t2_ack", 64'(ack), 64'h1);
        chk("t2_busy_low", 64'(busy), 64'h0);
        chk("t2_q", 64'(q), 64'h00);
        req = '0;
        tick();

        // 3: all four requesting, from a fresh rr pointer
        do_reset();
        tick();
        for (int i = 0; i < NREQ; i++) set_cmd(i, 1, 0, i);
        for (int n = 0; n < 5; n++) begin
            tick();
            tick();
            chk("t3_order", 64'(ack), 64'(1 << exp_order[n]));
        end
        req = '0;
        tick();
        chk("t3_q", 64'(q), 64'h0F);

        // 4: conflict on a set flag holds it
        set_cmd(0, 1, 0, 5);
        tick(); tick();
        req = '0;
        tick();
        set_cmd(0, 1, 1, 5);
        tick(); tick();
        chk("t4_q5", 64'(q[5]), 64'h1);
        chk("t4_ack", 64'(ack), 64'h1);
`ifdef SR_ARB_CONFLICT_CNT_EN
        chk("t4_cnt1", 64'(conflict_cnt), 64'd1);
`endif
        for (int n = 0; n < 299; n++) begin tick(); tick(); end
        req = '0;
        tick();
        chk("t4_q_final", 64'(q), 64'h2F);
`ifdef SR_ARB_CONFLICT_CNT_EN
        chk("t4_cnt_sat", 64'(conflict_cnt), 64'd255);
`endif

        // 5: reset while a command is in APPLY
        set_cmd(2, 1, 0, 7);
        tick();
        rst = 1'b0;
        req = '0;
        #1;
        chk("t5_q", 64'(q), 64'h0);
        chk("t5_ack", 64'(ack), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        model_reset();
        tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("t5_q_after", 64'(q), 64'h0);
        chk("t5_ack_after", 64'(ack), 64'h0);

        // 6: fields change and req drops after grant
        set_cmd(1, 1, 0, 2);
        tick();
        req_idx[1*IDXW +: IDXW] = 3'd6;
        req[1] = 1'b0;
        tick();
        chk("t6_ack", 64'(ack), 64'h2);
        chk("t6_q", 64'(q), 64'h04);
        tick();
        chk("t6_ack_once", 64'(ack), 64'h0);

        // Random traffic honouring the hold-until-ack handshake
        for (int i = 0; i < NREQ; i++) waitcnt[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    for (int o = 0; o < NREQ; o++)
                        if (o != i && req[o]) waitcnt[o]++;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (mack[i]) begin
                    chk("fairness", 64'(waitcnt[i] <= NREQ), 64'h1);
                    waitcnt[i] = 0;
                    if ($urandom_range(1) == 0) req[i] = 1'b0;
                    else set_cmd(i, 1'($urandom), 1'($urandom), int'($urandom_range(NFLAG - 1)));
                end else if (!req[i] && $urandom_range(2) == 0) begin
                    waitcnt[i] = 0;
                    set_cmd(i, 1'($urandom), 1'($urandom), int'($urandom_range(NFLAG - 1)));
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
